// File: rtl/uart_cmd_sequencer.sv
// UART command sequencer: frames the received byte stream into
// SYNC/CMD/DATA/CHK packets, validates them and drives the Pong
// game-control registers. Every output is driven straight from a flop.
module uart_cmd_sequencer #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic       i_CLK,
    input  logic       i_RST_N,
    input  logic       i_DataValid,
    input  logic [7:0] i_Rx_Byte,
    output logic [1:0] o_P1_Dir,
    output logic [1:0] o_P2_Dir,
    output logic       o_Start,
    output logic       o_Paused,
    output logic [3:0] o_BallSpeed,
    output logic       o_CmdValid,
    output logic       o_ErrPulse,
    output logic [7:0] o_ErrCount
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        GET_CMD,
        GET_DATA,
        GET_CHK,
        EXEC
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [7:0]  data_q, data_d;
    logic        exec_q, exec_d;
    logic [1:0]  p1_dir_q, p1_dir_d;
    logic [1:0]  p2_dir_q, p2_dir_d;
    logic        start_q, start_d;
    logic        paused_q, paused_d;
    logic [3:0]  speed_q, speed_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic        err_pulse_q, err_pulse_d;
    logic [7:0]  err_count_q, err_count_d;
    logic [7:0]  chk_expected;
    logic        err_event;

    // Next-state logic: packet framing, inter-byte timeout, and the decode
    // stage that applies a validated command one cycle after EXEC.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        cmd_d        = cmd_q;
        data_d       = data_q;
        exec_d       = 1'b0;
        p1_dir_d     = p1_dir_q;
        p2_dir_d     = p2_dir_q;
        start_d      = 1'b0;
        paused_d     = paused_q;
        speed_d      = speed_q;
        cmd_valid_d  = 1'b0;
        err_pulse_d  = 1'b0;
        err_count_d  = err_count_q;
        err_event    = 1'b0;
        chk_expected = cmd_q + data_q;

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (i_DataValid && (i_Rx_Byte == SYNC_BYTE)) begin
                    state_d = GET_CMD;
                end
            end
            GET_CMD: begin
                if (i_DataValid) begin
                    cmd_d   = i_Rx_Byte;
                    timer_d = '0;
                    state_d = GET_DATA;
                end
            end
            GET_DATA: begin
                if (i_DataValid) begin
                    data_d  = i_Rx_Byte;
                    timer_d = '0;
                    state_d = GET_CHK;
                end
            end
            GET_CHK: begin
                if (i_DataValid) begin
                    timer_d = '0;
                    if (i_Rx_Byte == chk_expected) begin
                        state_d = EXEC;
                    end else begin
                        state_d   = IDLE;
                        err_event = 1'b1;
                    end
                end
            end
            EXEC: begin
                exec_d  = 1'b1;
                timer_d = '0;
                state_d = IDLE;
            end
            default: begin
                timer_d = '0;
                state_d = IDLE;
            end
        endcase

        if ((state_q == GET_CMD || state_q == GET_DATA || state_q == GET_CHK)
            && !i_DataValid) begin
            if (timer_q == TIMEOUT_LAST) begin
                timer_d   = '0;
                state_d   = IDLE;
                err_event = 1'b1;
            end else begin
                timer_d = timer_q + 16'd1;
            end
        end

        if (exec_q) begin
            case (cmd_q)
                8'h01: begin
                    p1_dir_d    = (data_q[1:0] == 2'b11) ? 2'b00 : data_q[1:0];
                    cmd_valid_d = 1'b1;
                end
                8'h02: begin
                    p2_dir_d    = (data_q[1:0] == 2'b11) ? 2'b00 : data_q[1:0];
                    cmd_valid_d = 1'b1;
                end
                8'h10: begin
                    start_d     = 1'b1;
                    cmd_valid_d = 1'b1;
                end
                8'h11: begin
                    paused_d    = ~paused_q;
                    cmd_valid_d = 1'b1;
                end
                8'h20: begin
                    speed_d     = (data_q[3:0] == 4'd0) ? 4'd1 : data_q[3:0];
                    cmd_valid_d = 1'b1;
                end
                default: begin
                    err_event = 1'b1;
                end
            endcase
        end

        if (err_event) begin
            err_pulse_d = 1'b1;
            if (err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_CLK) begin
        if (!i_RST_N) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            cmd_q       <= '0;
            data_q      <= '0;
            exec_q      <= 1'b0;
            p1_dir_q    <= 2'b00;
            p2_dir_q    <= 2'b00;
            start_q     <= 1'b0;
            paused_q    <= 1'b0;
            speed_q     <= 4'd4;
            cmd_valid_q <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            cmd_q       <= cmd_d;
            data_q      <= data_d;
            exec_q      <= exec_d;
            p1_dir_q    <= p1_dir_d;
            p2_dir_q    <= p2_dir_d;
            start_q     <= start_d;
            paused_q    <= paused_d;
            speed_q     <= speed_d;
            cmd_valid_q <= cmd_valid_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    assign o_P1_Dir    = p1_dir_q;
    assign o_P2_Dir    = p2_dir_q;
    assign o_Start     = start_q;
    assign o_Paused    = paused_q;
    assign o_BallSpeed = speed_q;
    assign o_CmdValid  = cmd_valid_q;
    assign o_ErrPulse  = err_pulse_q;
    assign o_ErrCount  = err_count_q;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Testbench for uart_cmd_sequencer: drives framed packets, keeps a
// scoreboard of expected result pulses and checks outputs when they occur.
module tb_uart_cmd_sequencer;

    localparam logic [7:0] SYNC    = 8'hA5;
    localparam int         TIMEOUT = 20;

    logic       i_CLK = 1'b0;
    logic       i_RST_N = 1'b0;
    logic       i_DataValid = 1'b0;
    logic [7:0] i_Rx_Byte = 8'h00;
    logic [1:0] o_P1_Dir;
    logic [1:0] o_P2_Dir;
    logic       o_Start;
    logic       o_Paused;
    logic [3:0] o_BallSpeed;
    logic       o_CmdValid;
    logic       o_ErrPulse;
    logic [7:0] o_ErrCount;

    typedef struct {
        bit         isErr;
        int         due;
        logic [1:0] p1;
        logic [1:0] p2;
        logic       paused;
        logic [3:0] speed;
        logic       start;
        logic [7:0] errCnt;
    } expect_t;

    expect_t    sbQueue[$];
    expect_t    monEntry;
    int         checks = 0;
    int         failures = 0;
    int         cycle = 0;
    bit         monitorOn = 1'b0;

    logic [1:0] mP1 = 2'b00;
    logic [1:0] mP2 = 2'b00;
    logic       mPaused = 1'b0;
    logic [3:0] mSpeed = 4'd4;
    logic [7:0] mErr = 8'd0;

    uart_cmd_sequencer #(
        .SYNC_BYTE      (SYNC),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .i_CLK       (i_CLK),
        .i_RST_N     (i_RST_N),
        .i_DataValid (i_DataValid),
        .i_Rx_Byte   (i_Rx_Byte),
        .o_P1_Dir    (o_P1_Dir),
        .o_P2_Dir    (o_P2_Dir),
        .o_Start     (o_Start),
        .o_Paused    (o_Paused),
        .o_BallSpeed (o_BallSpeed),
        .o_CmdValid  (o_CmdValid),
        .o_ErrPulse  (o_ErrPulse),
        .o_ErrCount  (o_ErrCount)
    );

    // Free-running clock.
    always #5 i_CLK = ~i_CLK;

    // Edge counter used to time expected pulses.
    always @(posedge i_CLK) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                     tag, actual, expected, cycle);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_p1"}, 32'(o_P1_Dir), 32'(mP1));
        checkOutput({tag, "_p2"}, 32'(o_P2_Dir), 32'(mP2));
        checkOutput({tag, "_paused"}, 32'(o_Paused), 32'(mPaused));
        checkOutput({tag, "_speed"}, 32'(o_BallSpeed), 32'(mSpeed));
        checkOutput({tag, "_errcnt"}, 32'(o_ErrCount), 32'(mErr));
        checkOutput({tag, "_start"}, 32'(o_Start), 32'd0);
        checkOutput({tag, "_valid"}, 32'(o_CmdValid), 32'd0);
        checkOutput({tag, "_errpulse"}, 32'(o_ErrPulse), 32'd0);
    endtask

    // Scoreboard consumer: every result pulse must match the queue head in
    // timing and output values; a due entry with no pulse is a miss.
    always @(negedge i_CLK) begin
        if (monitorOn && i_RST_N) begin
            if (o_Start && !o_CmdValid) checkOutput("start_without_valid", 32'd1, 32'd0);
            if (o_CmdValid || o_ErrPulse) begin
                if (sbQueue.size() == 0) begin
                    checkOutput("unexpected_pulse", {30'd0, o_CmdValid, o_ErrPulse}, 32'd0);
                end else begin
                    monEntry = sbQueue.pop_front();
                    checkOutput("pulse_cycle", 32'(cycle), 32'(monEntry.due));
                    checkOutput("cmd_valid", 32'(o_CmdValid), 32'(!monEntry.isErr));
                    checkOutput("err_pulse", 32'(o_ErrPulse), 32'(monEntry.isErr));
                    checkOutput("p1_dir", 32'(o_P1_Dir), 32'(monEntry.p1));
                    checkOutput("p2_dir", 32'(o_P2_Dir), 32'(monEntry.p2));
                    checkOutput("paused", 32'(o_Paused), 32'(monEntry.paused));
                    checkOutput("ball_speed", 32'(o_BallSpeed), 32'(monEntry.speed));
                    checkOutput("start", 32'(o_Start), 32'(monEntry.start));
                    checkOutput("err_count", 32'(o_ErrCount), 32'(monEntry.errCnt));
                end
            end else if (sbQueue.size() > 0 && cycle >= sbQueue[0].due) begin
                checkOutput("missing_pulse", 32'd0, 32'd1);
                void'(sbQueue.pop_front());
            end
        end
    end

    task automatic pushExpect(input bit isErr, input int due, input logic start);
        expect_t e;
        if (isErr) mErr = (mErr == 8'hFF) ? 8'hFF : mErr + 8'd1;
        e.isErr  = isErr;
        e.due    = due;
        e.p1     = mP1;
        e.p2     = mP2;
        e.paused = mPaused;
        e.speed  = mSpeed;
        e.start  = start;
        e.errCnt = mErr;
        sbQueue.push_back(e);
    endtask

    // Drive one byte strobe so that it is sampled on edge number 'target'.
    task automatic driveByte(input logic [7:0] b, input int target, output int strobe);
        do @(negedge i_CLK); while (cycle < target - 1);
        i_DataValid = 1'b1;
        i_Rx_Byte   = b;
        strobe      = cycle + 1;
        @(negedge i_CLK);
        i_DataValid = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b, output int strobe);
        driveByte(b, cycle + 2, strobe);
    endtask

    task automatic applyStimulus(input logic [7:0] cmd, input logic [7:0] data,
                                 input logic [7:0] chk);
        int s;
        int chkStrobe;
        logic [7:0] sum;
        sendByte(SYNC, s);
        sendByte(cmd, s);
        sendByte(data, s);
        chkStrobe = cycle + 2;
        sum = cmd + data;
        if (chk != sum) begin
            pushExpect(1'b1, chkStrobe, 1'b0);
        end else begin
            case (cmd)
                8'h01: begin
                    mP1 = (data[1:0] == 2'b11) ? 2'b00 : data[1:0];
                    pushExpect(1'b0, chkStrobe + 2, 1'b0);
                end
                8'h02: begin
                    mP2 = (data[1:0] == 2'b11) ? 2'b00 : data[1:0];
                    pushExpect(1'b0, chkStrobe + 2, 1'b0);
                end
                8'h10: pushExpect(1'b0, chkStrobe + 2, 1'b1);
                8'h11: begin
                    mPaused = ~mPaused;
                    pushExpect(1'b0, chkStrobe + 2, 1'b0);
                end
                8'h20: begin
                    mSpeed = (data[3:0] == 4'd0) ? 4'd1 : data[3:0];
                    pushExpect(1'b0, chkStrobe + 2, 1'b0);
                end
                default: pushExpect(1'b1, chkStrobe + 2, 1'b0);
            endcase
        end
        driveByte(chk, chkStrobe, s);
    endtask

    task automatic waitDrain(input string tag);
        int n = 0;
        while (sbQueue.size() > 0 && n < 200) begin
            @(negedge i_CLK);
            n++;
        end
        repeat (4) @(negedge i_CLK);
        checkOutput({tag, "_drain"}, 32'(sbQueue.size()), 32'd0);
        sbQueue.delete();
    endtask

    // Safety net so the run can never hang.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int s;
        int e;

        repeat (3) @(negedge i_CLK);
        checkIdleOutputs("reset");
        i_RST_N = 1'b1;
        monitorOn = 1'b1;

        applyStimulus(8'h01, 8'h01, 8'h02);
        waitDrain("p1_up");
        checkIdleOutputs("after_p1_up");

        applyStimulus(8'h02, 8'h02, 8'h05);
        applyStimulus(8'h10, 8'h00, 8'h10);
        waitDrain("badchk_start");

        sendByte(SYNC, s);
        sendByte(8'h01, e);
        pushExpect(1'b1, e + TIMEOUT, 1'b0);
        while (cycle < e + TIMEOUT + 3) @(negedge i_CLK);
        waitDrain("timeout");

        sendByte(SYNC, s);
        sendByte(8'h01, e);
        driveByte(8'h02, e + TIMEOUT, s);
        mP1 = 2'b10;
        pushExpect(1'b0, cycle + 4, 1'b0);
        sendByte(8'h03, s);
        waitDrain("timeout_edge");

        applyStimulus(8'h20, 8'h00, 8'h20);
        applyStimulus(8'h20, 8'h0F, 8'h2F);
        applyStimulus(8'h11, 8'h00, 8'h11);
        applyStimulus(8'h11, 8'h00, 8'h11);
        applyStimulus(8'h02, 8'h01, 8'h03);
        applyStimulus(8'h01, 8'h03, 8'h04);
        waitDrain("controls");

        applyStimulus(8'h7E, 8'h00, 8'h7E);
        applyStimulus(SYNC, 8'h00, SYNC);
        waitDrain("unknown");
        checkIdleOutputs("after_unknown");

        for (int i = 0; i < 300; i++) applyStimulus(8'h02, 8'h02, 8'h05);
        waitDrain("saturate");
        checkOutput("errcount_saturated", 32'(o_ErrCount), 32'd255);

        sendByte(SYNC, s);
        sendByte(8'h01, s);
        @(negedge i_CLK);
        i_RST_N = 1'b0;
        @(negedge i_CLK);
        i_RST_N = 1'b1;
        mP1 = 2'b00; mP2 = 2'b00; mPaused = 1'b0; mSpeed = 4'd4; mErr = 8'd0;
        checkIdleOutputs("midpacket_reset");

        sendByte(8'h01, s);
        sendByte(8'h01, s);
        sendByte(8'h02, s);
        repeat (6) @(negedge i_CLK);
        checkIdleOutputs("no_sync_ignored");

        applyStimulus(8'h02, 8'h02, 8'h04);
        waitDrain("post_reset");
        checkIdleOutputs("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_cmd_sequencer.md
Name: uart_cmd_sequencer

Overview:
- Sequences the byte stream from the UART receiver (byte + one-cycle valid strobe) into framed 4-byte command packets from the PC.
- Validates each packet and drives the Pong game-control registers: paddle directions, start, pause and ball speed.
- Sits between the UART receiver and the game logic; one instance per receive link.

Parameters:
- SYNC_BYTE, 8'hA5, packet header value.
- TIMEOUT_CYCLES, 50000, max clock cycles allowed between consecutive bytes within a packet; range 2..65535; 16-bit counter.

Ports:
- i_CLK  in  1  system clock.
- i_RST_N  in  1  synchronous reset, active-low.
- i_DataValid  in  1  one-cycle strobe from the UART receiver; i_Rx_Byte is valid in that cycle.
- i_Rx_Byte  in  8  received byte.
- o_P1_Dir  out  2  paddle 1 direction: 00 stop, 01 up, 10 down.
- o_P2_Dir  out  2  paddle 2 direction, same encoding.
- o_Start  out  1  one-cycle game-start pulse.
- o_Paused  out  1  pause level.
- o_BallSpeed  out  4  ball speed setting.
- o_CmdValid  out  1  one-cycle pulse for each executed packet.
- o_ErrPulse  out  1  one-cycle pulse for each rejected packet.
- o_ErrCount  out  8  saturating count of rejected packets.

Behaviour:
- Packet format: SYNC, CMD, DATA, CHK, where CHK = (CMD + DATA) mod 256.
- Reset, on any edge with i_RST_N=0, including mid-packet:
  - State=IDLE; timeout counter=0.
  - Outputs: o_P1_Dir=0, o_P2_Dir=0, o_Start=0, o_Paused=0, o_BallSpeed=4'd4, o_CmdValid=0, o_ErrPulse=0, o_ErrCount=0.
  - Any partial packet is discarded without an error.
- States: IDLE, GET_CMD, GET_DATA, GET_CHK, EXEC.
- IDLE:
  - On a byte equal to SYNC_BYTE -> GET_CMD.
  - Any other byte is ignored: no error, no count.
- GET_CMD: on a byte, latch CMD -> GET_DATA.
  - A byte equal to SYNC_BYTE is accepted as a CMD value; there is no resync.
- GET_DATA: on a byte, latch DATA -> GET_CHK.
- GET_CHK: on a byte, compare it to (CMD+DATA)[7:0].
  - Match -> EXEC.
  - Mismatch -> IDLE with an error.
- Timeout, active in GET_CMD, GET_DATA and GET_CHK:
  - The counter clears on entry to each state and on each accepted byte, and increments every cycle with no byte.
  - When the count reaches TIMEOUT_CYCLES-1 with no byte that cycle -> IDLE with an error.
  - A byte arriving in the same cycle as the timeout has priority: it is accepted, no timeout.
- EXEC (exactly one cycle) decodes the latched CMD, then -> IDLE:
  - 0x01: o_P1_Dir <= DATA[1:0], with 11 mapped to 00.
  - 0x02: o_P2_Dir <= DATA[1:0], with 11 mapped to 00.
  - 0x10: o_Start pulses for one cycle.
  - 0x11: o_Paused <= ~o_Paused; DATA is ignored.
  - 0x20: o_BallSpeed <= DATA[3:0]; DATA=0 is clamped to 1.
  - Any other CMD: no register change, counted as an error.
- Any byte arriving during EXEC is dropped; it is not treated as a SYNC.
- Latency: the outputs, o_CmdValid and o_Start change on the second rising edge after the edge that samples the CHK byte's valid strobe.
- Errors (checksum mismatch, timeout, unknown CMD):
  - o_ErrPulse=1 for one cycle.
  - o_ErrCount increments, saturating at 255; it never wraps.
  - Control outputs are unchanged on any error.
  - A checksum or timeout error asserts o_ErrPulse on the edge that enters IDLE.
  - An unknown-CMD error asserts o_ErrPulse in place of o_CmdValid, with the same latency.
- o_CmdValid and o_ErrPulse are never both high.
- All outputs are registered; there are no combinational paths from input to output.

Test Plan:
- Reset then A5 01 01 02 -> o_P1_Dir=01, one o_CmdValid pulse exactly 2 edges after the CHK strobe, o_ErrCount=0.
- A5 02 02 05 (bad checksum) -> o_P2_Dir stays 00, one o_ErrPulse, o_ErrCount=1; then A5 10 00 10 -> single o_Start pulse.
- A5 01 with no third byte for TIMEOUT_CYCLES (set TIMEOUT_CYCLES=20) -> returns to IDLE, o_ErrCount increments; a byte arriving exactly on cycle 19 is accepted with no error.
- A5 20 00 20 -> o_BallSpeed=1; A5 20 0F 2F -> o_BallSpeed=15; two A5 11 00 11 packets -> o_Paused 0->1->0.
- A5 7E 00 7E (unknown CMD) -> o_ErrPulse, no output change; 300 bad packets -> o_ErrCount holds at 255.
- Assert i_RST_N=0 for 1 cycle after A5 01 -> all outputs return to reset values; next bytes 01 01 02 (no SYNC) are ignored; a following complete packet executes normally.
